// File: rtl/decode_queue_stage.sv
// MIPS decode stage: a small instruction queue feeding a registered decode bundle
// with a valid/ready handshake, a single-bubble load-use interlock and a flush.
module decode_queue_stage #(
  parameter int unsigned QDEPTH = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr_32,
  input  logic [31:0]       in_pc_32,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr_32,
  output logic [31:0]       out_pc_32,
  output logic              out_alu_op,
  output logic              out_unsigned_op,
  output logic              out_imm_op,
  output logic              out_byte_op,
  output logic              out_shift_op,
  output logic              out_mem_op,
  output logic              out_write_op,
  output logic              out_branch_op,
  output logic              out_jump_op,
  output logic              out_reg_jump_op,
  output logic              out_nop,
  output logic [5:0]        out_op_type_6,
  output logic [4:0]        out_rs_5,
  output logic [4:0]        out_rt_5,
  output logic [4:0]        out_rd_5,
  output logic [4:0]        out_sh_amt_5,
  output logic [5:0]        out_func_6,
  output logic [15:0]       out_imm_16,
  output logic [25:0]       out_target_26,
  output logic [CNT_W-1:0]  bubble_count
);

  localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  localparam logic [5:0] OpSpecial = 6'h00;
  localparam logic [5:0] OpRegimm  = 6'h01;
  localparam logic [5:0] OpJ       = 6'h02;
  localparam logic [5:0] OpJal     = 6'h03;
  localparam logic [5:0] OpBeq     = 6'h04;
  localparam logic [5:0] OpBne     = 6'h05;
  localparam logic [5:0] OpBlez    = 6'h06;
  localparam logic [5:0] OpBgtz    = 6'h07;
  localparam logic [5:0] OpAddiu   = 6'h09;
  localparam logic [5:0] OpSlti    = 6'h0A;
  localparam logic [5:0] OpSltiu   = 6'h0B;
  localparam logic [5:0] OpOri     = 6'h0D;
  localparam logic [5:0] OpXori    = 6'h0E;
  localparam logic [5:0] OpLui     = 6'h0F;
  localparam logic [5:0] OpLb      = 6'h20;
  localparam logic [5:0] OpLw      = 6'h23;
  localparam logic [5:0] OpLbu     = 6'h24;
  localparam logic [5:0] OpSb      = 6'h28;
  localparam logic [5:0] OpSw      = 6'h2B;

  localparam logic [5:0] FnSll  = 6'h00;
  localparam logic [5:0] FnSrl  = 6'h02;
  localparam logic [5:0] FnSra  = 6'h03;
  localparam logic [5:0] FnJr   = 6'h08;
  localparam logic [5:0] FnJalr = 6'h09;
  localparam logic [5:0] FnAddu = 6'h21;
  localparam logic [5:0] FnSubu = 6'h23;
  localparam logic [5:0] FnSltu = 6'h2B;

  // Instruction fields are sliced from instr, so only the word, PC and control are stored.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        alu;
    logic        uns;
    logic        imm;
    logic        byt;
    logic        shift;
    logic        mem;
    logic        wr;
    logic        br;
    logic        jmp;
    logic        rjmp;
    logic        nop;
    logic [5:0]  op_type;
  } bundle_t;

  function automatic bundle_t decode(input logic [31:0] w, input logic [31:0] pc);
    bundle_t    b;
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rt;
    b       = '0;
    b.instr = w;
    b.pc    = pc;
    op      = w[31:26];
    fn      = w[5:0];
    rt      = w[20:16];
    case (op)
      OpSpecial: begin
        if (fn == FnSll && w[10:6] == 5'd0) begin
          b.nop = 1'b1;
        end else if (fn == FnJr || fn == FnJalr) begin
          b.jmp  = 1'b1;
          b.rjmp = 1'b1;
        end else begin
          b.alu   = 1'b1;
          b.shift = (fn[5:3] == 3'b000);
          b.uns   = (fn == FnAddu) || (fn == FnSubu) || (fn == FnSltu);
        end
      end
      OpAddiu, OpSltiu: begin
        b.alu = 1'b1;
        b.imm = 1'b1;
        b.uns = 1'b1;
      end
      OpSlti, OpOri, OpXori: begin
        b.alu = 1'b1;
        b.imm = 1'b1;
      end
      OpLw, OpLui: begin
        b.mem = 1'b1;
        b.imm = 1'b1;
      end
      OpLb: begin
        b.mem = 1'b1;
        b.imm = 1'b1;
        b.byt = 1'b1;
      end
      OpLbu: begin
        b.mem = 1'b1;
        b.imm = 1'b1;
        b.byt = 1'b1;
        b.uns = 1'b1;
      end
      OpSw: begin
        b.mem = 1'b1;
        b.imm = 1'b1;
        b.wr  = 1'b1;
      end
      OpSb: begin
        b.mem = 1'b1;
        b.imm = 1'b1;
        b.byt = 1'b1;
        b.wr  = 1'b1;
      end
      OpJ: b.jmp = 1'b1;
      OpJal: begin
        b.jmp  = 1'b1;
        b.rjmp = 1'b1;
        b.imm  = 1'b1;
      end
      OpBeq, OpBne, OpBlez, OpBgtz: b.br = 1'b1;
      // Only BLTZ (rt=0) and BGEZ (rt=1) are decoded; other REGIMM forms are nops.
      OpRegimm: begin
        if (rt == 5'd0 || rt == 5'd1) b.br = 1'b1;
        else                          b.nop = 1'b1;
      end
      default: b.nop = 1'b1;
    endcase
    if (!b.nop) begin
      if (op == OpSpecial)     b.op_type = fn;
      else if (op == OpRegimm) b.op_type = {1'b0, rt};
      else                     b.op_type = op;
    end
    return b;
  endfunction

  function automatic logic reads_rs(input bundle_t b);
    logic [5:0] op;
    op = b.instr[31:26];
    return !b.nop && !(op inside {OpJ, OpJal, OpLui}) &&
           !(op == OpSpecial && (b.instr[5:0] inside {FnSll, FnSrl, FnSra}));
  endfunction

  function automatic logic reads_rt(input bundle_t b);
    return !b.nop && (b.instr[31:26] inside {OpSpecial, OpBeq, OpBne, OpSw, OpSb});
  endfunction

  logic [63:0]      ent_q [QDEPTH];
  logic [63:0]      ent_d [QDEPTH];
  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             out_valid_q, out_valid_d;
  bundle_t          out_q, out_d;
  logic [CNT_W-1:0] bubble_q, bubble_d;

  bundle_t head;
  logic    push, pop, out_load, out_is_load, hazard;
  logic [4:0] out_rt;

  // Reset gating keeps in_ready low while reset is held, independent of flush.
  assign in_ready = (count_q < CW'(QDEPTH)) & ~flush & ~reset;
  assign push     = in_valid & in_ready;
  assign out_load = ~out_valid_q | out_ready;

  assign head        = decode(ent_q[rptr_q][63:32], ent_q[rptr_q][31:0]);
  assign out_rt      = out_q.instr[20:16];
  assign out_is_load = out_q.mem & ~out_q.wr & (out_q.instr[31:26] != OpLui);
  assign hazard      = out_valid_q & out_is_load & (out_rt != 5'd0) &
                       ((reads_rs(head) & (head.instr[25:21] == out_rt)) |
                        (reads_rt(head) & (head.instr[20:16] == out_rt)));

  // Next-state for queue, output register and bubble counter.
  always_comb begin
    ent_d       = ent_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    bubble_d    = bubble_q;
    pop         = 1'b0;
    if (flush) begin
      wptr_d      = '0;
      rptr_d      = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
      out_d       = '0;
    end else begin
      if (out_load) begin
        if (count_q != '0) begin
          out_valid_d = 1'b1;
          if (hazard) begin
            // Bubble: all-zero word decodes as a nop; keep the held head's PC.
            out_d     = '0;
            out_d.pc  = head.pc;
            out_d.nop = 1'b1;
            if (bubble_q != '1) bubble_d = bubble_q + CNT_W'(1);
          end else begin
            out_d = head;
            pop   = 1'b1;
          end
        end else begin
          out_valid_d = 1'b0;
        end
      end
      if (push) begin
        ent_d[wptr_q] = {in_instr_32, in_pc_32};
        wptr_d        = wptr_q + PW'(1);
      end
      if (pop) rptr_d = rptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ent_q       <= '{default: '0};
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      bubble_q    <= '0;
    end else begin
      ent_q       <= ent_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      bubble_q    <= bubble_d;
    end
  end

  assign out_valid       = out_valid_q;
  assign out_instr_32    = out_q.instr;
  assign out_pc_32       = out_q.pc;
  assign out_alu_op      = out_q.alu;
  assign out_unsigned_op = out_q.uns;
  assign out_imm_op      = out_q.imm;
  assign out_byte_op     = out_q.byt;
  assign out_shift_op    = out_q.shift;
  assign out_mem_op      = out_q.mem;
  assign out_write_op    = out_q.wr;
  assign out_branch_op   = out_q.br;
  assign out_jump_op     = out_q.jmp;
  assign out_reg_jump_op = out_q.rjmp;
  assign out_nop         = out_q.nop;
  assign out_op_type_6   = out_q.op_type;
  assign out_rs_5        = out_q.instr[25:21];
  assign out_rt_5        = out_q.instr[20:16];
  assign out_rd_5        = out_q.instr[15:11];
  assign out_sh_amt_5    = out_q.instr[10:6];
  assign out_func_6      = out_q.instr[5:0];
  assign out_imm_16      = out_q.instr[15:0];
  assign out_target_26   = out_q.instr[25:0];
  assign bubble_count    = bubble_q;

endmodule

// File: doc/decode_queue_stage.md
# decode_queue_stage

Registered MIPS instruction-decode stage with a parametrised instruction queue in front of it. It accepts fetched instructions over a valid/ready handshake and buffers up to QDEPTH of them. Each instruction is decoded into the team's standard control bundle and presented in an output register with its own valid/ready handshake. A load-use interlock inserts one bubble, and a flush input discards all in-flight work. It sits between fetch and the register-read/execute stage.

## Interface
- QDEPTH, 4, queue entries; power of two, ≥2
- CNT_W, 16, width of the saturating bubble counter
- clock  in  1  rising-edge clock; the only clock
- reset  in  1  asynchronous, active-high
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  queue can accept; equals (count < QDEPTH) & !flush
- in_instr_32  in  32  instruction word
- in_pc_32  in  32  instruction address
- flush  in  1  discard queue and output register
- out_valid  out  1  output register holds a bundle
- out_ready  in  1  downstream accepts the bundle
- out_instr_32, out_pc_32  out  32  raw word and PC of the bundle
- out_alu_op, out_unsigned_op, out_imm_op, out_byte_op, out_shift_op, out_mem_op, out_write_op, out_branch_op, out_jump_op, out_reg_jump_op, out_nop  out  1 each  decoded control
- out_op_type_6  out  6  func for SPECIAL, {0,rt} for REGIMM, else opcode; 0 for nop
- out_rs_5, out_rt_5, out_rd_5, out_sh_amt_5  out  5  instruction fields
- out_func_6  out  6; out_imm_16  out  16; out_target_26  out  26  instruction fields
- bubble_count  out  CNT_W  saturating count of inserted bubbles

## Operation
- Queue: circular buffer with read/write pointers of log2(QDEPTH) bits and a count of log2(QDEPTH)+1 bits. Push on in_valid & in_ready. Pop when the head is loaded into the output register. A push and a pop in the same cycle leave count unchanged. Pointers wrap modulo QDEPTH.
- Decode is combinational on the queue head and uses the team's control table:
  - SPECIAL
  - Immediate ALU: ADDIU/SLTIU unsigned; SLTI, ORI, XORI signed.
  - Memory: LW, SW, LUI, LB, LBU, SB.
  - Jump/branch: J, JAL, BEQ, BNE, BGTZ, BLEZ.
  - REGIMM, and default → nop.
- REGIMM with rt=BGEZ/BLTZ gives branch_op=1 and nop=0. Any other rt gives nop=1.
- SLL with sh_amt=0 is a nop.
- Whenever nop=1, all op flags and op_type are 0.
- Load: mem_op & !write_op & opcode≠LUI.
- Source use:
  - rs is read by everything except J, JAL, LUI, SLL/SRL/SRA and nops.
  - rt is read by SPECIAL non-nop, BEQ, BNE, SW and SB.
- Hazard: out_valid, the output register holds a load with out_rt_5≠0, and the head reads a register equal to out_rt_5.
- Output register update when (!out_valid | out_ready):
  - count>0 and no hazard: load the head bundle, pop, out_valid←1.
  - count>0 and hazard: load a bubble without popping, out_valid←1, bubble_count += 1 (saturating at all-ones). A bubble has instr=0, nop=1, all flags 0, PC = head PC, fields 0.
  - count=0: out_valid←0.
- A bubble is never a load, so the held head issues on the next transfer.
- Otherwise the output register holds all outputs stable while out_valid & !out_ready.
- Flush (synchronous): count, pointers and out_valid ← 0. Any push in that cycle is dropped, since in_ready=0. bubble_count is kept.

## Timing
- Reset: in_ready=1 after reset deasserts; before that it is 0 because of flush-independent reset gating. out_valid=0, all out_* =0, bubble_count=0, count=0, pointers=0.
- Reset asserted mid-operation clears state immediately, without waiting for a clock edge.
- Latency: an instruction pushed at edge N into an empty stage with an idle output register reaches out_valid=1 after edge N+1.
- Throughput: one bundle per cycle while out_ready=1 and no hazard.
- Full: count=QDEPTH gives in_ready=0, combinationally in the same cycle. A pop frees space for a push in the next cycle only, so there is no full-bypass.
- Empty: the output register does not load; there is no queue bypass.
- in_ready never depends on out_ready.

## Test plan
- Stream: push 8 ADDU words with out_ready=1, QDEPTH=4 → 8 bundles out in order. First bundle out_valid appears 2 edges after the first push. alu_op=1, unsigned_op=1, op_type=0x21. No bubbles.
- Full/backpressure: out_ready=0, push 6 instructions → 5 accepted (4 in the queue plus 1 in the output register). in_ready=0 from then on. Outputs stay stable. Release → order preserved.
- Load-use: LW 0x8D280000, then ADDU 0x010B5021 → LW bundle, then a bubble (nop=1), then ADDU. bubble_count=1. Repeating with LW rt=0 (0x8D200000) → no bubble.
- Decode corners:
  - 0x00000000 → nop=1, op_type=0.
  - REGIMM rt=1 (0x05210004) → branch_op=1, op_type=0x01.
  - REGIMM rt=3 → nop=1.
  - JAL → jump_op=1, reg_jump_op=1, imm_op=1.
- Flush: fill 3 entries with out_valid=1, assert flush together with in_valid → next cycle count=0, out_valid=0, the new word is not queued, bubble_count is unchanged.
- Async reset mid-stream: assert reset between edges → outputs reach reset values before the next edge. Stream restarts cleanly after release.
